// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_flags
//  Purpose  : Parametrised single-clock FIFO with internal storage, registered
//             empty/full and programmable almost-empty/almost-full flags, an
//             occupancy count, sticky overflow/underflow errors, synchronous
//             flush, and a selectable registered or first-word-fall-through
//             read mode.
//  Ports    : clock        - single clock, all state on posedge
//             reset        - asynchronous, active-low reset
//             flush        - synchronous clear of pointers, count, flags, errors
//             push/in_data - write request and write data
//             pop          - read request
//             out_data     - read data
//             out_valid    - out_data is valid
//             full, empty, almost_full, almost_empty - occupancy flags
//             count        - occupancy 0..DEPTH
//             overflow     - sticky: push rejected because FIFO was full
//             underflow    - sticky: pop rejected because FIFO was empty
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int AF_LEVEL     = 14,
    parameter int AE_LEVEL     = 2,
    parameter int FWFT         = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESSWIDTH:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                      c_CW       = ADDRESSWIDTH + 1;
    localparam logic [ADDRESSWIDTH-1:0] c_LAST_PTR = ADDRESSWIDTH'(DEPTH - 1);
    localparam logic [c_CW-1:0]         c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]         c_AF       = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0]         c_AE       = c_CW'(AE_LEVEL);

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [ADDRESSWIDTH-1:0] r_front;
    logic [ADDRESSWIDTH-1:0] r_rear;
    logic [c_CW-1:0]         r_count;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_almost_full;
    logic                    r_almost_empty;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_pop_acc;
    logic                    w_push_acc;
    logic [c_CW-1:0]         w_count_next;
    logic [ADDRESSWIDTH-1:0] w_front_next;
    logic [ADDRESSWIDTH-1:0] w_rear_next;

    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle; the flags come from registers, never from pointers.
    always_comb begin
        w_pop_acc    = pop & ~r_empty;
        w_push_acc   = push & (~r_full | w_pop_acc);
        w_count_next = r_count + c_CW'(w_push_acc) - c_CW'(w_pop_acc);
        w_front_next = (r_front == c_LAST_PTR) ? '0 : r_front + ADDRESSWIDTH'(1);
        w_rear_next  = (r_rear  == c_LAST_PTR) ? '0 : r_rear  + ADDRESSWIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_front        <= '0;
            r_rear         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (flush) begin
            r_front        <= '0;
            r_rear         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_pop_acc) begin
                r_front <= w_front_next;
            end
            if (w_push_acc) begin
                r_rear <= w_rear_next;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == c_DEPTH);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= c_AF);
            r_almost_empty <= (w_count_next <= c_AE);
            r_overflow     <= r_overflow  | (push & r_full & ~w_pop_acc);
            r_underflow    <= r_underflow | (pop & r_empty);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (reset && !flush && w_push_acc) begin
            r_mem[r_rear] <= in_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally while the FIFO holds data;
            // r_last keeps the most recently shown word so out_data holds
            // still once the FIFO drains or is flushed.
            logic [WIDTH-1:0] r_last;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_last <= '0;
                end else if (!r_empty) begin
                    r_last <= r_mem[r_front];
                end
            end

            assign out_valid = ~r_empty;
            assign out_data  = r_empty ? r_last : r_mem[r_front];
        end else begin : g_registered
            logic [WIDTH-1:0] r_out_data;
            logic             r_out_valid;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_pop_acc;
                    if (w_pop_acc) begin
                        r_out_data <= r_mem[r_front];
                    end
                end
            end

            assign out_valid = r_out_valid;
            assign out_data  = r_out_data;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_flags
//  Purpose  : Directed bench for fifo_sync_flags. Instance A is the default
//             16-deep registered-read FIFO; instance B is 12 deep with
//             first-word-fall-through reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    logic clk = 1'b0;
    logic reset_n;

    logic        flush_a, push_a, pop_a;
    logic [15:0] din_a, dout_a;
    logic        vld_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [4:0]  cnt_a;

    logic        flush_b, push_b, pop_b;
    logic [15:0] din_b, dout_b;
    logic        vld_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [4:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .WIDTH(16), .DEPTH(16), .ADDRESSWIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
    ) u_dut_a (
        .clock(clk), .reset(reset_n), .flush(flush_a), .push(push_a), .in_data(din_a),
        .pop(pop_a), .out_data(dout_a), .out_valid(vld_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a),
        .underflow(unf_a)
    );

    fifo_sync_flags #(
        .WIDTH(16), .DEPTH(12), .ADDRESSWIDTH(4), .AF_LEVEL(10), .AE_LEVEL(2), .FWFT(1)
    ) u_dut_b (
        .clock(clk), .reset(reset_n), .flush(flush_b), .push(push_b), .in_data(din_b),
        .pop(pop_b), .out_data(dout_b), .out_valid(vld_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b),
        .underflow(unf_b)
    );

    // {out_data, out_valid, full, empty, almost_full, almost_empty, count, overflow, underflow}
    localparam logic [27:0] c_RESET_VEC = {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] v;
        reset_n = 1'b0;
        flush_a = 0; push_a = 0; pop_a = 0; din_a = '0;
        flush_b = 0; push_b = 0; pop_b = 0; din_b = '0;
        #12;
        v = {dout_a, vld_a, full_a, empty_a, af_a, ae_a, cnt_a, ovf_a, unf_a};
        n_cmp++; if (v !== c_RESET_VEC) begin n_err++; $display("FAIL reset_a: got %h want %h", v, c_RESET_VEC); end
        v = {dout_b, vld_b, full_b, empty_b, af_b, ae_b, cnt_b, ovf_b, unf_b};
        n_cmp++; if (v !== c_RESET_VEC) begin n_err++; $display("FAIL reset_b: got %h want %h", v, c_RESET_VEC); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push_a = 1'b1; din_a = 16'(i);
            step();
            if (i == 13) begin
                n_cmp++; if (af_a !== 1'b0) begin n_err++; $display("FAIL fill_af13: got %b want 0", af_a); end
            end
            if (i == 14) begin
                n_cmp++; if (af_a !== 1'b1) begin n_err++; $display("FAIL fill_af14: got %b want 1", af_a); end
            end
            if (i == 15) begin
                n_cmp++; if (full_a !== 1'b0) begin n_err++; $display("FAIL fill_full15: got %b want 0", full_a); end
            end
        end
        push_a = 1'b0;
        n_cmp++; if (full_a !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full_a); end
        n_cmp++; if (cnt_a !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", cnt_a); end
        n_cmp++; if (empty_a !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", empty_a); end
    endtask

    task automatic test_overflow_drain();
        push_a = 1'b1; din_a = 16'hFFFF;
        step();
        push_a = 1'b0;
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf_a); end
        n_cmp++; if (cnt_a !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", cnt_a); end
        step();
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf_a); end
        for (int i = 1; i <= 16; i++) begin
            pop_a = 1'b1;
            step();
            n_cmp++; if (vld_a !== 1'b1) begin n_err++; $display("FAIL drain_valid%0d: got %b want 1", i, vld_a); end
            n_cmp++; if (dout_a !== 16'(i)) begin n_err++; $display("FAIL drain_data%0d: got %h want %h", i, dout_a, 16'(i)); end
            n_cmp++; if (cnt_a !== 5'(16 - i)) begin n_err++; $display("FAIL drain_count%0d: got %0d want %0d", i, cnt_a, 16 - i); end
            if (i == 13) begin
                n_cmp++; if (ae_a !== 1'b0) begin n_err++; $display("FAIL drain_ae3: got %b want 0", ae_a); end
            end
            if (i == 14) begin
                n_cmp++; if (ae_a !== 1'b1) begin n_err++; $display("FAIL drain_ae2: got %b want 1", ae_a); end
            end
        end
        pop_a = 1'b0;
        step();
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL drain_idle_valid: got %b want 0", vld_a); end
        n_cmp++; if (dout_a !== 16'h0010) begin n_err++; $display("FAIL drain_hold: got %h want 0010", dout_a); end
    endtask

    task automatic test_underflow_flush();
        pop_a = 1'b1;
        step();
        pop_a = 1'b0;
        n_cmp++; if (unf_a !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", unf_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL unf_valid: got %b want 0", vld_a); end
        n_cmp++; if (cnt_a !== 5'd0) begin n_err++; $display("FAIL unf_count: got %0d want 0", cnt_a); end
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        n_cmp++; if (unf_a !== 1'b0) begin n_err++; $display("FAIL flush_unf: got %b want 0", unf_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL flush_ovf: got %b want 0", ovf_a); end
        n_cmp++; if (dout_a !== 16'h0010) begin n_err++; $display("FAIL flush_hold: got %h want 0010", dout_a); end
        // push and pop together on an empty FIFO: only the push lands
        push_a = 1'b1; pop_a = 1'b1; din_a = 16'h0077;
        step();
        push_a = 1'b0; pop_a = 1'b0;
        n_cmp++; if (cnt_a !== 5'd1) begin n_err++; $display("FAIL pp_empty_count: got %0d want 1", cnt_a); end
        n_cmp++; if (unf_a !== 1'b1) begin n_err++; $display("FAIL pp_empty_unf: got %b want 1", unf_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL pp_empty_valid: got %b want 0", vld_a); end
        pop_a = 1'b1;
        step();
        pop_a = 1'b0;
        n_cmp++; if (dout_a !== 16'h0077) begin n_err++; $display("FAIL pp_empty_data: got %h want 0077", dout_a); end
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            push_a = 1'b1; din_a = 16'h0100 + 16'(i); q.push_back(din_a);
            step();
        end
        n_cmp++; if (full_a !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", full_a); end
        for (int k = 0; k < 20; k++) begin
            push_a = 1'b1; pop_a = 1'b1; din_a = 16'h0200 + 16'(k);
            q.push_back(din_a);
            step();
            exp = q.pop_front();
            n_cmp++; if (dout_a !== exp || vld_a !== 1'b1) begin n_err++; $display("FAIL b2b_data%0d: got %h/%b want %h/1", k, dout_a, vld_a, exp); end
            n_cmp++; if (cnt_a !== 5'd16) begin n_err++; $display("FAIL b2b_count%0d: got %0d want 16", k, cnt_a); end
            n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL b2b_ovf%0d: got %b want 0", k, ovf_a); end
        end
        push_a = 1'b0; pop_a = 1'b0;
    endtask

    task automatic test_fwft();
        logic [15:0] qb[$];
        bit          p, o, pa, wa, eovf, eunf;
        logic [15:0] d;
        eovf = 1'b0; eunf = 1'b0;
        push_b = 1'b1; din_b = 16'hA5A5;
        step();
        push_b = 1'b0;
        qb.push_back(16'hA5A5);
        n_cmp++; if (vld_b !== 1'b1) begin n_err++; $display("FAIL fwft_first_valid: got %b want 1", vld_b); end
        n_cmp++; if (dout_b !== 16'hA5A5) begin n_err++; $display("FAIL fwft_first_data: got %h want a5a5", dout_b); end
        for (int c = 0; c < 30; c++) begin
            p = ($urandom_range(0, 2) != 0);
            o = ($urandom_range(0, 1) != 0);
            d = 16'($urandom);
            n_cmp++; if (vld_b !== (qb.size() != 0)) begin n_err++; $display("FAIL fwft_valid%0d: got %b want %b", c, vld_b, qb.size() != 0); end
            if (qb.size() != 0) begin
                n_cmp++; if (dout_b !== qb[0]) begin n_err++; $display("FAIL fwft_data%0d: got %h want %h", c, dout_b, qb[0]); end
            end
            pa = o && (qb.size() > 0);
            wa = p && ((qb.size() < 12) || pa);
            eovf = eovf | (p && (qb.size() == 12) && !pa);
            eunf = eunf | (o && (qb.size() == 0));
            push_b = p; pop_b = o; din_b = d;
            step();
            if (pa) void'(qb.pop_front());
            if (wa) qb.push_back(d);
            n_cmp++; if (cnt_b !== 5'(qb.size())) begin n_err++; $display("FAIL fwft_count%0d: got %0d want %0d", c, cnt_b, qb.size()); end
            n_cmp++; if (full_b !== (qb.size() == 12)) begin n_err++; $display("FAIL fwft_full%0d: got %b want %b", c, full_b, qb.size() == 12); end
            n_cmp++; if ({ovf_b, unf_b} !== {eovf, eunf}) begin n_err++; $display("FAIL fwft_err%0d: got %b%b want %b%b", c, ovf_b, unf_b, eovf, eunf); end
        end
        push_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (qb.size() != 0) begin
                n_cmp++; if (dout_b !== qb[0] || vld_b !== 1'b1) begin n_err++; $display("FAIL fwft_drain%0d: got %h/%b want %h/1", c, dout_b, vld_b, qb[0]); end
                pop_b = 1'b1;
                step();
                void'(qb.pop_front());
            end
        end
        pop_b = 1'b0;
        n_cmp++; if (empty_b !== 1'b1 || vld_b !== 1'b0) begin n_err++; $display("FAIL fwft_empty: got %b/%b want 1/0", empty_b, vld_b); end
    endtask

    task automatic test_reset_flush();
        logic [27:0] v;
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_a = 1'b1; din_a = 16'h0030 + 16'(i);
            step();
        end
        n_cmp++; if (cnt_a !== 5'd7) begin n_err++; $display("FAIL burst_count: got %0d want 7", cnt_a); end
        din_a = 16'h0099;
        #2 reset_n = 1'b0;
        #1;
        v = {dout_a, vld_a, full_a, empty_a, af_a, ae_a, cnt_a, ovf_a, unf_a};
        n_cmp++; if (v !== c_RESET_VEC) begin n_err++; $display("FAIL async_reset: got %h want %h", v, c_RESET_VEC); end
        push_a = 1'b0;
        #2 reset_n = 1'b1;
        step();
        n_cmp++; if (empty_a !== 1'b1 || cnt_a !== 5'd0) begin n_err++; $display("FAIL post_reset: got %b/%0d want 1/0", empty_a, cnt_a); end
        for (int i = 0; i < 3; i++) begin
            push_a = 1'b1; din_a = 16'h0040 + 16'(i);
            step();
        end
        flush_a = 1'b1;
        step();
        flush_a = 1'b0; push_a = 1'b0;
        n_cmp++; if (cnt_a !== 5'd0) begin n_err++; $display("FAIL flush_push_count: got %0d want 0", cnt_a); end
        n_cmp++; if (empty_a !== 1'b1 || ae_a !== 1'b1) begin n_err++; $display("FAIL flush_push_flags: got %b/%b want 1/1", empty_a, ae_a); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_flush();
        test_back_to_back();
        test_fwft();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
